// File: rtl/mem_access_seq_pkg.sv
// Shared types for the memory-access sequencer: size codes, FSM states and
// the alignment rule applied to incoming requests.
package mem_access_seq_pkg;

  typedef enum logic [1:0] {
    SZ_NONE = 2'b00,
    SZ_BYTE = 2'b01,
    SZ_HALF = 2'b10,
    SZ_WORD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_FIN  = 2'b11
  } state_e;

  function automatic logic is_misaligned(input size_e sz, input logic [1:0] lo);
    logic mis;
    mis = 1'b0;
    case (sz)
      SZ_HALF: mis = lo[0];
      SZ_WORD: mis = (lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_seq_if.sv
// Request/response and memory bus of the sequencer; slave is the sequencer side.
interface mem_access_seq_if;
  logic        i_start;
  logic        i_is_store;
  logic [1:0]  i_size;
  logic [31:0] i_addr;
  logic [31:0] i_store_data;
  logic [31:0] i_mem_rdata;
  logic [31:0] o_mem_addr;
  logic        o_mem_wr;
  logic [31:0] o_mem_wdata;
  logic [31:0] o_load_data;
  logic        o_busy;
  logic        o_done;
  logic        o_misaligned;

  modport slave (
    input  i_start, i_is_store, i_size, i_addr, i_store_data, i_mem_rdata,
    output o_mem_addr, o_mem_wr, o_mem_wdata, o_load_data, o_busy, o_done, o_misaligned
  );

  modport master (
    output i_start, i_is_store, i_size, i_addr, i_store_data, i_mem_rdata,
    input  o_mem_addr, o_mem_wr, o_mem_wdata, o_load_data, o_busy, o_done, o_misaligned
  );
endinterface

// File: rtl/mem_access_seq_lane_merge.sv
// Lane datapath: extracts a zero-extended byte/half/word from a memory word
// and merges store data into the selected lane of that word.
module lane_merge
  import mem_access_seq_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [31:0] i_data,
  input  size_e       i_size,
  input  logic [1:0]  i_lane,
  output logic [31:0] o_extracted,
  output logic [31:0] o_merged
);

  logic [4:0] w_byte_sh;
  logic [4:0] w_half_sh;

  assign w_byte_sh = {i_lane, 3'b000};
  assign w_half_sh = {i_lane[1], 4'b0000};

  // Lane select for both directions; non-selected lanes pass through on merge.
  always_comb begin
    o_extracted = 32'h0000_0000;
    o_merged    = i_word;
    case (i_size)
      SZ_BYTE: begin
        o_extracted = {24'h00_0000, i_word[w_byte_sh +: 8]};
        o_merged[w_byte_sh +: 8] = i_data[7:0];
      end
      SZ_HALF: begin
        o_extracted = {16'h0000, i_word[w_half_sh +: 16]};
        o_merged[w_half_sh +: 16] = i_data[15:0];
      end
      SZ_WORD: begin
        o_extracted = i_word;
        o_merged    = i_data;
      end
      default: begin
        o_extracted = 32'h0000_0000;
        o_merged    = i_word;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_seq.sv
// Multicycle load/store sequencer for a word-wide memory without byte enables;
// sub-word stores are read-modify-write, loads are lane-extracted.
module mem_access_seq
  import mem_access_seq_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int CNT_W       = 3
) (
  input logic              i_clock,
  input logic              i_reset,
  mem_access_seq_if.slave  bus
);

  state_e           r_state;
  state_e           w_next;
  logic             r_is_store;
  size_e            r_size;
  logic [1:0]       r_lane;
  logic [31:0]      r_store_data;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_mem_addr;
  logic [31:0]      r_mem_wdata;
  logic [31:0]      r_load_data;
  logic             r_mem_wr;
  logic             r_busy;
  logic             r_done;
  logic             r_misaligned;

  logic             w_req;
  logic             w_req_mis;
  logic             w_rd_last;
  size_e            w_req_size;
  logic             w_busy_nx;
  logic             w_done_nx;
  logic             w_wr_nx;
  logic             w_mis_nx;
  logic [31:0]      w_extracted;
  logic [31:0]      w_merged;

  assign w_req      = (r_state == ST_IDLE) && bus.i_start;
  assign w_req_size = size_e'(bus.i_size);
  assign w_req_mis  = is_misaligned(w_req_size, bus.i_addr[1:0]);
  // Capture happens on the last of MEM_LATENCY read cycles.
  assign w_rd_last  = (r_state == ST_RD) && (r_cnt == CNT_W'(MEM_LATENCY - 1));

  lane_merge u_lane_merge (
    .i_word      (bus.i_mem_rdata),
    .i_data      (r_store_data),
    .i_size      (r_size),
    .i_lane      (r_lane),
    .o_extracted (w_extracted),
    .o_merged    (w_merged)
  );

  // State register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!w_req) begin
          w_next = ST_IDLE;
        end else if ((w_req_size == SZ_NONE) || w_req_mis) begin
          w_next = ST_FIN;
        end else if (bus.i_is_store && (w_req_size == SZ_WORD)) begin
          w_next = ST_WR;
        end else begin
          w_next = ST_RD;
        end
      end
      ST_RD: begin
        if (!w_rd_last) begin
          w_next = ST_RD;
        end else if (r_is_store) begin
          w_next = ST_WR;
        end else begin
          w_next = ST_FIN;
        end
      end
      ST_WR:   w_next = ST_FIN;
      ST_FIN:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so the status outputs can be registered.
  always_comb begin
    w_busy_nx = (w_next != ST_IDLE);
    w_done_nx = (w_next == ST_FIN);
    w_wr_nx   = (w_next == ST_WR);
    if (w_req) begin
      w_mis_nx = w_req_mis && (w_next == ST_FIN);
    end else begin
      w_mis_nx = 1'b0;
    end
  end

  // Request latch, latency counter, data capture and registered outputs.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_is_store   <= 1'b0;
      r_size       <= SZ_NONE;
      r_lane       <= 2'b00;
      r_store_data <= 32'h0000_0000;
      r_cnt        <= {CNT_W{1'b0}};
      r_mem_addr   <= 32'h0000_0000;
      r_mem_wdata  <= 32'h0000_0000;
      r_load_data  <= 32'h0000_0000;
      r_mem_wr     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      r_busy       <= w_busy_nx;
      r_done       <= w_done_nx;
      r_mem_wr     <= w_wr_nx;
      r_misaligned <= w_mis_nx;
      if ((r_state == ST_RD) && (w_next == ST_RD)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= {CNT_W{1'b0}};
      end
      if (w_req) begin
        r_is_store   <= bus.i_is_store;
        r_size       <= w_req_size;
        r_lane       <= bus.i_addr[1:0];
        r_store_data <= bus.i_store_data;
        r_mem_addr   <= {bus.i_addr[31:2], 2'b00};
        r_mem_wdata  <= bus.i_store_data;
      end else if (w_rd_last) begin
        if (r_is_store) begin
          r_mem_wdata <= w_merged;
        end else begin
          r_load_data <= w_extracted;
        end
      end
    end
  end

  assign bus.o_mem_addr   = r_mem_addr;
  assign bus.o_mem_wr     = r_mem_wr;
  assign bus.o_mem_wdata  = r_mem_wdata;
  assign bus.o_load_data  = r_load_data;
  assign bus.o_busy       = r_busy;
  assign bus.o_done       = r_done;
  assign bus.o_misaligned = r_misaligned;

endmodule

// File: tb/tb_mem_access_seq.sv
// Bench for mem_access_seq: two instances (latency 1 and 3) share the request
// stimulus; a transaction-level model predicts every output cycle by cycle.
module tb_mem_access_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_d;
  logic        st_d;
  logic [1:0]  sz_d;
  logic [31:0] addr_d;
  logic [31:0] data_d;
  logic [31:0] rdata_d [2];

  always #5 clk = ~clk;

  mem_access_seq_if bus1 ();
  mem_access_seq_if bus3 ();

  assign bus1.i_start = start_d;       assign bus3.i_start = start_d;
  assign bus1.i_is_store = st_d;       assign bus3.i_is_store = st_d;
  assign bus1.i_size = sz_d;           assign bus3.i_size = sz_d;
  assign bus1.i_addr = addr_d;         assign bus3.i_addr = addr_d;
  assign bus1.i_store_data = data_d;   assign bus3.i_store_data = data_d;
  assign bus1.i_mem_rdata = rdata_d[0];
  assign bus3.i_mem_rdata = rdata_d[1];

  mem_access_seq #(.MEM_LATENCY(1), .CNT_W(3)) dut1 (.i_clock(clk), .i_reset(rst), .bus(bus1.slave));
  mem_access_seq #(.MEM_LATENCY(3), .CNT_W(3)) dut3 (.i_clock(clk), .i_reset(rst), .bus(bus3.slave));

  logic [31:0] o_addr [2], o_wdata [2], o_ld [2];
  logic        o_wr [2], o_busy [2], o_done [2], o_mis [2];
  assign o_addr[0] = bus1.o_mem_addr;   assign o_addr[1] = bus3.o_mem_addr;
  assign o_wdata[0] = bus1.o_mem_wdata; assign o_wdata[1] = bus3.o_mem_wdata;
  assign o_ld[0] = bus1.o_load_data;    assign o_ld[1] = bus3.o_load_data;
  assign o_wr[0] = bus1.o_mem_wr;       assign o_wr[1] = bus3.o_mem_wr;
  assign o_busy[0] = bus1.o_busy;       assign o_busy[1] = bus3.o_busy;
  assign o_done[0] = bus1.o_done;       assign o_done[1] = bus3.o_done;
  assign o_mis[0] = bus1.o_misaligned;  assign o_mis[1] = bus3.o_misaligned;

  // Memory seen by each DUT and the image the model expects it to hold.
  logic [31:0] mem [2][256];
  logic [31:0] exp_mem [2][256];
  int lat [2] = '{1, 3};

  // Model state per instance: k is the cycle index, start sampled in cycle 0.
  bit          act [2] = '{0, 0};
  int          k [2] = '{0, 0};
  int          done_c [2], wr_c [2], rd_c [2];
  int          widx [2];
  logic [31:0] e_addr [2], e_wdata [2], e_ld_new [2];
  logic [31:0] e_ld [2] = '{32'h0, 32'h0};
  bit          e_mis [2], is_ld [2];
  int          done_cnt [2] = '{0, 0};
  int          last_done_k [2] = '{-1, -1};
  int          last_wr_k [2] = '{-1, -1};
  logic [31:0] last_wdata [2];
  logic        last_mis [2];

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic accept(input int d);
    logic [31:0] w;
    int sh;
    e_addr[d] = {addr_d[31:2], 2'b00};
    widx[d]   = int'(addr_d[9:2]);
    w         = exp_mem[d][widx[d]];
    e_mis[d]  = (sz_d == 2'd2 && addr_d[0]) || (sz_d == 2'd3 && addr_d[1:0] != 2'd0);
    is_ld[d]  = 1'b0;
    rd_c[d]   = 0;
    wr_c[d]   = 0;
    if (sz_d == 2'd0 || e_mis[d]) begin
      done_c[d] = 1;
    end else if (st_d && sz_d == 2'd3) begin
      wr_c[d] = 1; done_c[d] = 2; e_wdata[d] = data_d;
    end else begin
      rd_c[d] = lat[d];
      if (st_d) begin
        wr_c[d] = lat[d] + 1; done_c[d] = lat[d] + 2;
        if (sz_d == 2'd1) begin
          sh = 8 * int'(addr_d[1:0]);
          e_wdata[d] = (w & ~(32'hFF << sh)) | ({24'h0, data_d[7:0]} << sh);
        end else begin
          sh = 16 * int'(addr_d[1]);
          e_wdata[d] = (w & ~(32'hFFFF << sh)) | ({16'h0, data_d[15:0]} << sh);
        end
      end else begin
        is_ld[d] = 1'b1; done_c[d] = lat[d] + 1;
        if (sz_d == 2'd1)      e_ld_new[d] = (w >> (8 * int'(addr_d[1:0]))) & 32'hFF;
        else if (sz_d == 2'd2) e_ld_new[d] = (w >> (16 * int'(addr_d[1]))) & 32'hFFFF;
        else                   e_ld_new[d] = w;
      end
    end
    act[d] = 1'b1;
    k[d]   = 1;
  endtask

  // Memory, model advance and per-cycle output comparison.
  always begin
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (o_wr[d]) mem[d][o_addr[d][9:2]] = o_wdata[d];
      if (rst) begin
        act[d] = 1'b0; e_ld[d] = 32'h0;
      end else if (act[d] && k[d] == done_c[d]) begin
        act[d] = 1'b0;
      end else if (act[d]) begin
        k[d]++;
      end else if (start_d) begin
        accept(d);
      end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      logic x_done, x_wr;
      x_done = act[d] && k[d] == done_c[d];
      x_wr   = act[d] && k[d] == wr_c[d];
      if (act[d] && rd_c[d] != 0 && k[d] == rd_c[d]) rdata_d[d] = mem[d][widx[d]];
      else rdata_d[d] = 32'h5A5A_0000 | 32'(k[d]);
      if (x_wr) exp_mem[d][widx[d]] = e_wdata[d];
      if (x_done && is_ld[d]) e_ld[d] = e_ld_new[d];
      chk($sformatf("busy[%0d]", d), {31'b0, o_busy[d]}, {31'b0, act[d]});
      chk($sformatf("done[%0d]", d), {31'b0, o_done[d]}, {31'b0, x_done});
      chk($sformatf("mem_wr[%0d]", d), {31'b0, o_wr[d]}, {31'b0, x_wr});
      chk($sformatf("misaligned[%0d]", d), {31'b0, o_mis[d]}, {31'b0, x_done && e_mis[d]});
      chk($sformatf("load_data[%0d]", d), o_ld[d], e_ld[d]);
      if (x_wr) chk($sformatf("mem_wdata[%0d]", d), o_wdata[d], e_wdata[d]);
      if (act[d]) chk($sformatf("mem_addr[%0d]", d), o_addr[d], e_addr[d]);
      if (o_done[d]) begin
        done_cnt[d]++; last_done_k[d] = act[d] ? k[d] : -1; last_mis[d] = o_mis[d];
      end
      if (o_wr[d]) begin
        last_wr_k[d] = act[d] ? k[d] : -1; last_wdata[d] = o_wdata[d];
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((act[0] || act[1]) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", {31'b0, act[0] | act[1]}, 32'd0);
  endtask

  task automatic req(input logic st, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] dat);
    @(negedge clk);
    start_d = 1'b1; st_d = st; sz_d = sz; addr_d = a; data_d = dat;
    @(negedge clk);
    start_d = 1'b0; st_d = 1'($urandom); sz_d = 2'($urandom); addr_d = $urandom; data_d = $urandom;
    wait_idle();
  endtask

  task automatic pin(input string name, input int d, input logic [31:0] got, input logic [31:0] exp);
    chk($sformatf("%s[%0d]", name, d), got, exp);
  endtask

  initial begin
    int dc [2];
    rst = 1'b1; start_d = 1'b0; st_d = 1'b0; sz_d = 2'd0; addr_d = 32'h0; data_d = 32'h0;
    rdata_d[0] = 32'h0; rdata_d[1] = 32'h0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 256; i++) begin
        mem[d][i] = 32'h1000_0000 + 32'(i);
        exp_mem[d][i] = 32'h1000_0000 + 32'(i);
      end
    for (int d = 0; d < 2; d++) begin mem[d][64] = 32'hAABB_CCDD; exp_mem[d][64] = 32'hAABB_CCDD; end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      pin("rst_busy", d, {31'b0, o_busy[d]}, 32'd0);
      pin("rst_addr", d, o_addr[d], 32'h0);
      pin("rst_wdata", d, o_wdata[d], 32'h0);
    end
    rst = 1'b0;

    req(1'b0, 2'd1, 32'h0000_0101, 32'h0);
    for (int d = 0; d < 2; d++) pin("ld_byte", d, o_ld[d], 32'h0000_00CC);
    pin("ld_done_cycle", 0, 32'(last_done_k[0]), 32'd2);
    pin("ld_done_cycle", 1, 32'(last_done_k[1]), 32'd4);

    req(1'b0, 2'd2, 32'h0000_0102, 32'h0);
    for (int d = 0; d < 2; d++) pin("ld_half", d, o_ld[d], 32'h0000_AABB);
    pin("ldh_done_cycle", 1, 32'(last_done_k[1]), 32'd4);

    req(1'b1, 2'd1, 32'h0000_0103, 32'h0000_0011);
    for (int d = 0; d < 2; d++) begin
      pin("stb_wdata", d, last_wdata[d], 32'h11BB_CCDD);
      pin("stb_keeps_ld", d, o_ld[d], 32'h0000_AABB);
    end
    pin("stb_wr_cycle", 0, 32'(last_wr_k[0]), 32'd2);
    pin("stb_done_cycle", 1, 32'(last_done_k[1]), 32'd5);
    req(1'b0, 2'd3, 32'h0000_0100, 32'h0);
    for (int d = 0; d < 2; d++) pin("ld_word", d, o_ld[d], 32'h11BB_CCDD);

    req(1'b1, 2'd3, 32'h0000_0100, 32'hAABB_CCDD);
    req(1'b1, 2'd2, 32'h0000_0100, 32'hFFFF_1234);
    for (int d = 0; d < 2; d++) pin("sth_wdata", d, last_wdata[d], 32'hAABB_1234);
    req(1'b1, 2'd3, 32'h0000_0100, 32'hDEAD_BEEF);
    for (int d = 0; d < 2; d++) begin
      pin("stw_wr_cycle", d, 32'(last_wr_k[d]), 32'd1);
      pin("stw_done_cycle", d, 32'(last_done_k[d]), 32'd2);
    end
    req(1'b1, 2'd3, 32'h0000_0100, 32'hAABB_CCDD);

    req(1'b0, 2'd3, 32'h0000_0102, 32'h0);
    for (int d = 0; d < 2; d++) begin
      pin("mis_flag", d, {31'b0, last_mis[d]}, 32'd1);
      pin("mis_done_cycle", d, 32'(last_done_k[d]), 32'd1);
    end
    req(1'b1, 2'd2, 32'h0000_0101, 32'h0000_9999);
    req(1'b0, 2'd0, 32'h0000_0100, 32'h0);
    for (int d = 0; d < 2; d++) begin
      pin("none_mis", d, {31'b0, last_mis[d]}, 32'd0);
      pin("mis_mem", d, mem[d][64], 32'hAABB_CCDD);
    end

    // Byte store aborted by reset while reading.
    for (int d = 0; d < 2; d++) dc[d] = done_cnt[d];
    @(negedge clk);
    start_d = 1'b1; st_d = 1'b1; sz_d = 2'd1; addr_d = 32'h0000_0100; data_d = 32'h0000_0077;
    @(negedge clk);
    start_d = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      pin("rst_mid_mem", d, mem[d][64], 32'hAABB_CCDD);
      pin("rst_mid_no_done", d, 32'(done_cnt[d] - dc[d]), 32'd0);
      pin("rst_mid_ld", d, o_ld[d], 32'h0);
    end

    // start held high through busy cycles is ignored.
    for (int d = 0; d < 2; d++) dc[d] = done_cnt[d];
    @(negedge clk);
    start_d = 1'b1; st_d = 1'b0; sz_d = 2'd1; addr_d = 32'h0000_0100; data_d = 32'h0;
    @(negedge clk);
    st_d = 1'b1; sz_d = 2'd3; data_d = 32'h1234_5678;
    @(negedge clk);
    start_d = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      pin("busy_start_dones", d, 32'(done_cnt[d] - dc[d]), 32'd1);
      pin("busy_start_mem", d, mem[d][64], 32'hAABB_CCDD);
      pin("busy_start_ld", d, o_ld[d], 32'h0000_00DD);
    end

    for (int d = 0; d < 2; d++) begin
      int bad = 0;
      for (int i = 0; i < 256; i++) if (mem[d][i] !== exp_mem[d][i]) bad++;
      pin("mem_image_errors", d, 32'(bad), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mem_access_seq.md
Name: mem_access_seq

Overview:
- Multicycle memory-access sequencer that sits directly downstream of the load/store size control.
- Takes a size-coded load or store request and drives a word-wide synchronous memory that has no byte enables.
- Byte and halfword stores are done as read-modify-write. Loads are lane-extracted and zero-extended.
- Reports done/busy back to the main control FSM.

Parameters:
- MEM_LATENCY, 1, cycles from mem_addr valid to mem_rdata valid (legal range 1..7).
- CNT_W, 3, width of the latency counter; must satisfy 2^CNT_W > MEM_LATENCY.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request strobe; sampled only in IDLE.
- is_store  in  1  1 = store, 0 = load.
- size  in  2  00 = none, 01 = byte, 10 = half, 11 = word.
- addr  in  32  byte address.
- store_data  in  32  store value; byte/half taken from bits [7:0]/[15:0].
- mem_rdata  in  32  memory read word.
- mem_addr  out  32  word-aligned address {addr[31:2],2'b00}.
- mem_wr  out  1  memory write strobe.
- mem_wdata  out  32  memory write word.
- load_data  out  32  extracted, zero-extended load result.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- misaligned  out  1  valid with done; request was not executed.

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset).
- Reset values: all outputs 0; state IDLE; latency counter 0.
- Request latch: in IDLE, start=1 latches addr, is_store, size and store_data. While busy, start is ignored (no queueing).
- States: IDLE, RD, WR, FIN.

Transitions out of IDLE on start:
- size=00 → FIN, no memory access.
- Misaligned request → FIN with misaligned=1, no memory access. Misaligned means half with addr[0]=1, or word with addr[1:0]≠0.
- Word store → WR.
- Any load, or a byte/half store → RD.

Other transitions:
- RD: hold mem_addr; count MEM_LATENCY cycles; on the last cycle capture mem_rdata. Then go to WR for a byte/half store, or FIN for a load.
- WR: mem_wr=1 for exactly one cycle → FIN.
- FIN: done=1 for one cycle → IDLE. misaligned is cleared when FIN exits.

Lane rules:
- Byte lane = addr[1:0]; lane 0 = bits [7:0].
- Half lane = addr[1]; lane 0 = bits [15:0].
- Load result: the selected lane, zero-extended.
- Byte/half store: mem_wdata = captured word with only the selected lane replaced.
- Word store: mem_wdata = store_data.

Latency (start sampled in cycle 0, L = MEM_LATENCY):
- Load: done in cycle L+1.
- Word store: mem_wr in cycle 1, done in cycle 2.
- Byte/half store: mem_wr in cycle L+1, done in cycle L+2.
- size=00 or misaligned: done in cycle 1.

Output holding:
- load_data is registered. It updates only at load completion and holds otherwise; stores do not change it.
- mem_addr is stable from cycle 1 until IDLE is re-entered.

Boundary conditions:
- Reset mid-operation (any state): the next edge forces IDLE with mem_wr=0 and done=0. A pending RMW write is dropped and memory is left unmodified.
- start coinciding with the FIN cycle is ignored.
- mem_rdata is ignored outside the capture cycle.

Decomposition:
- Shared package: size encodings (SZ_NONE, SZ_BYTE, SZ_HALF, SZ_WORD) and the state enum.
- One combinational sub-module, lane_merge, used for both extract and merge.
  - Inputs: word, data, size, lane.
  - Outputs: extracted, merged.

Test Plan (memory model: mem[0x100]=0xAABBCCDD, MEM_LATENCY=1 unless stated):
- Load byte, addr=0x101 → load_data=0x000000CC; done in cycle 2; mem_wr never asserted.
- Load half, addr=0x102 → load_data=0x0000AABB. Repeat with MEM_LATENCY=3 → done in cycle 4.
- Store byte, addr=0x103, data=0x00000011 → one mem_wr in cycle 2 with mem_wdata=0x11BBCCDD; then load word at 0x100 returns 0x11BBCCDD.
- Store half, addr=0x100, data=0xFFFF1234 → mem_wdata=0xAABB1234. Store word, 0x100, 0xDEADBEEF → mem_wr in cycle 1, done in cycle 2.
- Load word at addr=0x102, and store half at addr=0x101 → done+misaligned in cycle 1; no mem_wr; memory unchanged.
- Byte store with reset asserted in the RD cycle → IDLE next cycle; no mem_wr; mem[0x100] still 0xAABBCCDD. start pulsed while busy → ignored; exactly one done.
